// File: rtl/rtc_time_counter.sv
// rtl/rtc_time_counter.sv - 24-hour time-of-day counter driven by a synchronized 1 Hz input
module rtc_time_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       clk_1Hz,
  input  logic       set_en,
  input  logic       set_load,
  input  logic [1:0] set_field,
  input  logic [5:0] set_value,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       min_tick,
  output logic       day_tick,
  output logic       set_err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sec_tick;
  logic                   count_en;
  logic                   load_en;
  logic                   load_ok;

  // Binary 0..63 to two BCD digits by repeated subtraction of ten.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  // Bring the 1 Hz wave into this domain and remember its last synchronized level.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_1Hz};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising edge of the synchronized wave is one second; falling edges are ignored.
  assign sec_tick = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign count_en = sec_tick & ~set_en;
  assign load_en  = set_load & set_en;

  // Range check of a load against the selected field; field 3 is never accepted.
  always_comb begin
    load_ok = 1'b0;
    case (set_field)
      2'd0:    load_ok = (set_value <= 6'd59);
      2'd1:    load_ok = (set_value <= 6'd59);
      2'd2:    load_ok = (set_value <= 6'd23);
      default: load_ok = 1'b0;
    endcase
  end

  // Time fields and pulses: a load or a counted tick, never both since set_en separates them.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      seconds  <= 6'd0;
      minutes  <= 6'd0;
      hours    <= 5'd0;
      min_tick <= 1'b0;
      day_tick <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      min_tick <= 1'b0;
      day_tick <= 1'b0;
      set_err  <= 1'b0;
      if (load_en) begin
        if (load_ok) begin
          case (set_field)
            2'd0:    seconds <= set_value;
            2'd1:    minutes <= set_value;
            default: hours   <= set_value[4:0];
          endcase
        end else begin
          set_err <= 1'b1;
        end
      end else if (count_en) begin
        if (seconds == 6'd59) begin
          seconds  <= 6'd0;
          min_tick <= 1'b1;
          if (minutes == 6'd59) begin
            minutes <= 6'd0;
            if (hours == 5'd23) begin
              hours    <= 5'd0;
              day_tick <= 1'b1;
            end else begin
              hours <= hours + 5'd1;
            end
          end else begin
            minutes <= minutes + 6'd1;
          end
        end else begin
          seconds <= seconds + 6'd1;
        end
      end
    end
  end

  // BCD copies trail the binary fields by one edge.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sec_bcd  <= 8'h00;
      min_bcd  <= 8'h00;
      hour_bcd <= 8'h00;
    end else begin
      sec_bcd  <= to_bcd(seconds);
      min_bcd  <= to_bcd(minutes);
      hour_bcd <= to_bcd({1'b0, hours});
    end
  end

endmodule

// File: tb/tb_rtc_time_counter.sv
// tb/tb_rtc_time_counter.sv - directed self-checking bench for rtc_time_counter
module tb_rtc_time_counter;

  logic       clk_100MHz;
  logic       reset;
  logic       clk_1Hz;
  logic       set_en;
  logic       set_load;
  logic [1:0] set_field;
  logic [5:0] set_value;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic       min_tick;
  logic       day_tick;
  logic       set_err;

  int tests;
  int failed;

  rtc_time_counter #(.SYNC_STAGES(2)) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .clk_1Hz   (clk_1Hz),
    .set_en    (set_en),
    .set_load  (set_load),
    .set_field (set_field),
    .set_value (set_value),
    .seconds   (seconds),
    .minutes   (minutes),
    .hours     (hours),
    .sec_bcd   (sec_bcd),
    .min_bcd   (min_bcd),
    .hour_bcd  (hour_bcd),
    .min_tick  (min_tick),
    .day_tick  (day_tick),
    .set_err   (set_err)
  );

  // 100 MHz clock.
  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic load(input logic [1:0] f, input logic [5:0] v);
    set_field = f;
    set_value = v;
    set_load  = 1'b1;
    cyc(1);
    set_load  = 1'b0;
  endtask

  // Raise clk_1Hz mid-period and stop 1 ns after E3.
  task automatic tick_rise();
    #3 clk_1Hz = 1'b1;
    cyc(3);
  endtask

  task automatic tick_fall();
    clk_1Hz = 1'b0;
    cyc(4);
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    reset     = 1'b1;
    clk_1Hz   = 1'b0;
    set_en    = 1'b0;
    set_load  = 1'b0;
    set_field = 2'd0;
    set_value = 6'd0;
    cyc(3);
    #2 reset = 1'b0;
    cyc(2);

    // Reset state
    check("rst_sec", 32'(seconds), 32'd0);
    check("rst_min", 32'(minutes), 32'd0);
    check("rst_hour", 32'(hours), 32'd0);
    check("rst_bcd", {8'h00, sec_bcd, min_bcd, hour_bcd}, 32'h0);
    check("rst_pulses", {29'd0, min_tick, day_tick, set_err}, 32'd0);

    // Minute rollover
    set_en = 1'b1;
    load(2'd0, 6'd58);
    check("mr_load_sec", 32'(seconds), 32'd58);
    check("mr_load_err", 32'(set_err), 32'd0);
    set_en = 1'b0;
    tick_rise();
    check("mr_sec59", 32'(seconds), 32'd59);
    check("mr_no_mtick", 32'(min_tick), 32'd0);
    check("mr_bcd_lag", 32'(sec_bcd), 32'h58);
    cyc(1);
    check("mr_bcd59", 32'(sec_bcd), 32'h59);
    tick_fall();
    check("mr_fall_sec", 32'(seconds), 32'd59);
    tick_rise();
    check("mr_wrap_sec", 32'(seconds), 32'd0);
    check("mr_wrap_min", 32'(minutes), 32'd1);
    check("mr_mtick_hi", 32'(min_tick), 32'd1);
    check("mr_min_bcd_lag", 32'(min_bcd), 32'h00);
    cyc(1);
    check("mr_mtick_lo", 32'(min_tick), 32'd0);
    check("mr_min_bcd", 32'(min_bcd), 32'h01);
    check("mr_sec_bcd", 32'(sec_bcd), 32'h00);
    tick_fall();

    // Day wrap
    set_en = 1'b1;
    load(2'd2, 6'd23);
    load(2'd1, 6'd59);
    load(2'd0, 6'd59);
    cyc(1);
    check("dw_bcd_pre", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h00235959);
    set_en = 1'b0;
    tick_rise();
    check("dw_time", {11'd0, 5'(hours), 2'd0, minutes, 2'd0, seconds}, 32'd0);
    check("dw_dtick_hi", 32'(day_tick), 32'd1);
    check("dw_mtick_hi", 32'(min_tick), 32'd1);
    cyc(1);
    check("dw_dtick_lo", 32'(day_tick), 32'd0);
    check("dw_mtick_lo", 32'(min_tick), 32'd0);
    check("dw_hour_bcd", 32'(hour_bcd), 32'h00);
    tick_fall();

    // Rejected loads
    set_en = 1'b1;
    load(2'd0, 6'd60);
    check("rj_sec60_err", 32'(set_err), 32'd1);
    check("rj_sec60_val", 32'(seconds), 32'd0);
    cyc(1);
    check("rj_err_lo", 32'(set_err), 32'd0);
    load(2'd2, 6'd24);
    check("rj_hr24_err", 32'(set_err), 32'd1);
    check("rj_hr24_val", 32'(hours), 32'd0);
    load(2'd3, 6'd5);
    check("rj_f3_err", 32'(set_err), 32'd1);
    check("rj_time", {11'd0, 5'(hours), 2'd0, minutes, 2'd0, seconds}, 32'd0);
    load(2'd1, 6'd45);
    check("rj_min45_err", 32'(set_err), 32'd0);
    check("rj_min45_val", 32'(minutes), 32'd45);
    cyc(1);
    check("rj_min45_bcd", 32'(min_bcd), 32'h45);
    set_en = 1'b0;
    load(2'd0, 6'd60);
    check("rj_noen_err", 32'(set_err), 32'd0);
    load(2'd0, 6'd30);
    check("rj_noen_val", 32'(seconds), 32'd0);

    // Frozen while setting
    set_en = 1'b1;
    repeat (3) begin
      tick_rise();
      tick_fall();
    end
    check("fz_sec", 32'(seconds), 32'd0);
    check("fz_min", 32'(minutes), 32'd45);
    check("fz_mtick", 32'(min_tick), 32'd0);
    set_en = 1'b0;
    cyc(2);
    check("fz_release_sec", 32'(seconds), 32'd0);
    tick_rise();
    check("fz_resume_sec", 32'(seconds), 32'd1);
    check("fz_resume_min", 32'(minutes), 32'd45);
    tick_fall();

    // Latency check
    #3 clk_1Hz = 1'b1;
    cyc(1);
    check("lat_e1", 32'(seconds), 32'd1);
    cyc(1);
    check("lat_e2", 32'(seconds), 32'd1);
    cyc(1);
    check("lat_e3", 32'(seconds), 32'd2);
    cyc(1);
    check("lat_e4_hold", 32'(seconds), 32'd2);
    check("lat_e4_bcd", 32'(sec_bcd), 32'h02);
    #2 clk_1Hz = 1'b0;
    cyc(6);
    check("lat_fall", 32'(seconds), 32'd2);

    // Reset mid-count
    set_en = 1'b1;
    load(2'd2, 6'd12);
    load(2'd1, 6'd34);
    load(2'd0, 6'd56);
    set_en = 1'b0;
    cyc(1);
    check("rm_pre_bcd", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h00123456);
    #3 reset = 1'b1;
    #1;
    check("rm_time", {11'd0, 5'(hours), 2'd0, minutes, 2'd0, seconds}, 32'd0);
    check("rm_bcd", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h0);
    check("rm_pulses", {29'd0, min_tick, day_tick, set_err}, 32'd0);
    cyc(2);
    #2 reset = 1'b0;
    cyc(3);
    check("rm_after_rel", 32'(seconds), 32'd0);
    tick_rise();
    check("rm_restart_sec", 32'(seconds), 32'd1);
    check("rm_restart_min", 32'(minutes), 32'd0);
    check("rm_restart_mtick", 32'(min_tick), 32'd0);
    tick_fall();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rtc_time_counter.md
# rtc_time_counter

Time-of-day counter for the digital clock. It consumes the 1 Hz square wave produced by the 1 Hz timer stage and advances seconds, minutes and hours in 24-hour format. It provides binary and BCD time for the display path, and a one-cycle `day_tick` for the calendar stage. A user set port loads individual fields while counting is frozen.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `clk_1Hz`; legal values are 2 or 3.
- `clk_100MHz`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `clk_1Hz`  in  1  1 Hz square wave, 50% duty; each rising edge is one second.
- `set_en`  in  1  set mode; while high, second ticks are ignored and the time is frozen.
- `set_load`  in  1  single-cycle strobe; writes `set_value` into the field selected by `set_field`. Honoured only when `set_en` = 1.
- `set_field`  in  2  field select: 0 = seconds, 1 = minutes, 2 = hours, 3 = reserved.
- `set_value`  in  6  binary value to load.
- `seconds`  out  6  binary, 0..59.
- `minutes`  out  6  binary, 0..59.
- `hours`  out  5  binary, 0..23.
- `sec_bcd`, `min_bcd`, `hour_bcd`  out  8 each  BCD of the binary fields; [7:4] is tens, [3:0] is units; registered.
- `min_tick`  out  1  one-cycle pulse when seconds wrap 59→0.
- `day_tick`  out  1  one-cycle pulse on the 23:59:59→00:00:00 wrap.
- `set_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- **Synchronizer.** `clk_1Hz` passes through a `SYNC_STAGES`-deep flip-flop chain, then through one `prev` register.
  - `sec_tick = sync_last & ~prev`, combinational.
  - A falling edge produces no tick.
- **Counting.** A tick advances the time only when `set_en` = 0 in the same cycle. On a counted tick:
  - seconds + 1; at 59, seconds → 0, minutes + 1, and `min_tick` = 1.
  - minutes at 59 on carry → 0 and hours + 1.
  - hours at 23 on carry → 0 and `day_tick` = 1.
  - All fields update in the same clock edge (no ripple cycles).
- **Dropped ticks.** A tick arriving while `set_en` = 1 is discarded, not queued. Time resumes on the first tick after `set_en` falls.
- **Load.** A `set_load` with `set_en` = 1 acts as follows:
  - Field 0 or 1 with value ≤ 59, or field 2 with value ≤ 23: the selected field takes `set_value` at the next edge; other fields are unchanged.
  - Any out-of-range value, or field 3: no field changes and `set_err` = 1 for one cycle.
  - A `set_load` with `set_en` = 0 is ignored and does not raise `set_err`.
  - A load never generates `min_tick` or `day_tick`.
- **BCD outputs.** Registered from the binary fields; updated one edge after a binary change. Tens ≤ 5 for seconds/minutes and ≤ 2 for hours.
- **Reset.**
  - seconds, minutes, hours = 0.
  - All BCD outputs = 8'h00.
  - `min_tick`, `day_tick`, `set_err` = 0.
  - Synchronizer and `prev` registers = 0.
  - The upstream timer shares `reset`, so `clk_1Hz` is low at release and no spurious tick occurs.
  - Reset mid-count returns to 00:00:00 immediately; no pulse outputs fire.

## Timing
- With `SYNC_STAGES` = 2, `clk_1Hz` is first sampled high at edge E1. `sec_tick` is high between E2 and E3. Binary fields, `min_tick` and `day_tick` update at E3.
- BCD fields update at E4.
- Each additional sync stage adds one cycle.
- Exactly one tick is produced per `clk_1Hz` rising edge. Ticks are 100,000,000 cycles apart, so a tick and a load never interact except as below.
- **Simultaneous tick and load** (both in a cycle with `set_en` = 1): the tick is discarded; the load applies.
- **`set_en` falling in the same cycle as a tick:** `set_en` is sampled in that cycle. If it is 0, the tick counts.
- Pulse outputs are high for exactly one cycle. They are registered and aligned with the binary field update.

## Test plan
- **Minute rollover.** Load 00:00:58, drop `set_en`, give two `clk_1Hz` rising edges. Required: seconds = 59, then 00:01:00; `min_tick` pulses once; `min_bcd` = 8'h01 one cycle after the binary update.
- **Day wrap.** Load 23:59:59 and give one rising edge. Required: 00:00:00; `day_tick` and `min_tick` each high for exactly one cycle, at E3 after sampling; `hour_bcd` = 8'h00.
- **Rejected loads.** With `set_en` = 1, load seconds = 60, then hours = 24, then field 3. Required: three `set_err` pulses; time unchanged. A valid load of minutes = 45 gives `min_bcd` = 8'h45 and no `set_err`.
- **Frozen while setting.** Hold `set_en` = 1 across 3 `clk_1Hz` rising edges. Required: time unchanged. Release `set_en`; the next edge gives +1 second only.
- **Latency check.** Apply a `clk_1Hz` rising edge asynchronously mid-period. Required: seconds increment on the 3rd `clk_100MHz` edge after the first sampling edge; a falling edge produces no change.
- **Reset mid-count.** From 12:34:56, assert `reset` asynchronously between clock edges. Required: all outputs go to 0 immediately, with no pulse outputs; after release, counting restarts from 00:00:00 on the next `clk_1Hz` rising edge.
